// File: rtl/thres_gen.sv
// Binarisation stage: RGB565 -> 8-bit luma -> windowed 1-bit mask with pixel position.
// Three register stages from in_de/in_data to thres_de/thres_data; one pixel per clock.
module thres_gen #(
  parameter int unsigned H_ACT         = 480,
  parameter int unsigned V_ACT         = 272,
  parameter logic [7:0]  THRES_LO_INIT = 8'd128,
  parameter logic [7:0]  THRES_HI_INIT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vs,
  input  logic        in_de,
  input  logic [15:0] in_data,
  input  logic [7:0]  thres_lo,
  input  logic [7:0]  thres_hi,
  output logic [9:0]  loc_x,
  output logic [9:0]  loc_y,
  output logic        thres_data,
  output logic        thres_de,
  output logic        frame_done
);

  localparam int unsigned CW    = 10;
  localparam logic [CW-1:0] X_MAX = CW'(H_ACT - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(V_ACT - 1);

  logic          vs_prev_q, vs_prev_d, de_prev_q, de_prev_d;
  logic [CW-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [7:0]    lo_act_q, lo_act_d, hi_act_q, hi_act_d;
  logic [CW-1:0] pix_x, pix_y;
  logic          vs_rise;

  logic          s1_vld_q, s1_vld_d;
  logic [CW-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [7:0]    s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d;

  logic          s2_vld_q, s2_vld_d;
  logic [CW-1:0] s2_x_q, s2_x_d, s2_y_q, s2_y_d;
  logic [7:0]    s2_luma_q, s2_luma_d;
  logic [15:0]   sum;

  logic          thres_de_q, thres_de_d, thres_data_q, thres_data_d;
  logic          frame_done_q, frame_done_d;
  logic [CW-1:0] loc_x_q, loc_x_d, loc_y_q, loc_y_d;

  // Position tracking and per-frame bound capture; frame sync overrides line end.
  always_comb begin
    vs_rise   = in_vs & ~vs_prev_q;
    vs_prev_d = in_vs;
    de_prev_d = in_de;
    x_cnt_d   = x_cnt_q;
    y_cnt_d   = y_cnt_q;
    lo_act_d  = lo_act_q;
    hi_act_d  = hi_act_q;
    pix_x     = x_cnt_q;
    pix_y     = y_cnt_q;
    if (!in_de && de_prev_q) begin
      x_cnt_d = '0;
      y_cnt_d = (y_cnt_q == Y_MAX) ? y_cnt_q : y_cnt_q + CW'(1);
    end
    if (vs_rise) begin
      x_cnt_d  = '0;
      y_cnt_d  = '0;
      lo_act_d = thres_lo;
      hi_act_d = thres_hi;
      pix_x    = '0;
      pix_y    = '0;
    end
    if (in_de) begin
      x_cnt_d = (pix_x == X_MAX) ? pix_x : pix_x + CW'(1);
    end
  end

  // S1: colour expansion to 8 bits per channel.
  always_comb begin
    s1_vld_d = in_de;
    s1_x_d   = pix_x;
    s1_y_d   = pix_y;
    s1_r_d   = {in_data[15:11], in_data[15:13]};
    s1_g_d   = {in_data[10:5],  in_data[10:9]};
    s1_b_d   = {in_data[4:0],   in_data[4:2]};
  end

  // S2: weighted luma sum; max 65280 fits 16 bits.
  always_comb begin
    sum       = 16'd77  * {8'd0, s1_r_q}
              + 16'd150 * {8'd0, s1_g_q}
              + 16'd29  * {8'd0, s1_b_q};
    s2_vld_d  = s1_vld_q;
    s2_x_d    = s1_x_q;
    s2_y_d    = s1_y_q;
    s2_luma_d = 8'(sum >> 8);
  end

  // S3: window compare and output gating; an inverted window never matches.
  always_comb begin
    thres_de_d   = s2_vld_q;
    loc_x_d      = s2_vld_q ? s2_x_q : '0;
    loc_y_d      = s2_vld_q ? s2_y_q : '0;
    thres_data_d = s2_vld_q && (s2_luma_q >= lo_act_q) && (s2_luma_q <= hi_act_q);
    frame_done_d = s2_vld_q && (s2_x_q == X_MAX) && (s2_y_q == Y_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev_q    <= 1'b0;
      de_prev_q    <= 1'b0;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      lo_act_q     <= THRES_LO_INIT;
      hi_act_q     <= THRES_HI_INIT;
      s1_vld_q     <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_r_q       <= '0;
      s1_g_q       <= '0;
      s1_b_q       <= '0;
      s2_vld_q     <= 1'b0;
      s2_x_q       <= '0;
      s2_y_q       <= '0;
      s2_luma_q    <= '0;
      thres_de_q   <= 1'b0;
      thres_data_q <= 1'b0;
      frame_done_q <= 1'b0;
      loc_x_q      <= '0;
      loc_y_q      <= '0;
    end else begin
      vs_prev_q    <= vs_prev_d;
      de_prev_q    <= de_prev_d;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      lo_act_q     <= lo_act_d;
      hi_act_q     <= hi_act_d;
      s1_vld_q     <= s1_vld_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      s1_r_q       <= s1_r_d;
      s1_g_q       <= s1_g_d;
      s1_b_q       <= s1_b_d;
      s2_vld_q     <= s2_vld_d;
      s2_x_q       <= s2_x_d;
      s2_y_q       <= s2_y_d;
      s2_luma_q    <= s2_luma_d;
      thres_de_q   <= thres_de_d;
      thres_data_q <= thres_data_d;
      frame_done_q <= frame_done_d;
      loc_x_q      <= loc_x_d;
      loc_y_q      <= loc_y_d;
    end
  end

  assign thres_de   = thres_de_q;
  assign thres_data = thres_data_q;
  assign frame_done = frame_done_q;
  assign loc_x      = loc_x_q;
  assign loc_y      = loc_y_q;

endmodule
